eth_frame_gen: RTL and testbench
================================

Name: eth_frame_gen

Overview:
Parametrised Ethernet frame traffic generator that replaces fixed clock/reset-only stimulus in front of ethernet_top. It emits complete Layer-2 frames as a byte stream with a valid/ready handshake: destination MAC, source MAC, EtherType, deterministic payload, and CRC-32 FCS. Frame count, length mode and inter-frame gap are configurable, so the same block serves simulation benches and on-chip loopback tests.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first
SRC_MAC, 48'h0200_0000_0001, source MAC, sent MSB byte first
ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first
PAYLOAD_MIN, 46, minimum payload bytes; lengths below are clamped up
PAYLOAD_MAX, 1500, maximum payload bytes; lengths above are clamped down
IFG_CYCLES, 12, idle cycles with tx_valid low after each tx_last handshake
LEN_MODE, 0, 0 = fixed length from payload_len; 1 = incrementing length

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a run; ignored while busy
stop  in  1  finish the current frame, then end the run
num_frames  in  16  frames per run; 0 = continuous until stop
payload_len  in  11  payload bytes in fixed mode (sampled on start)
tx_data  out  8  stream byte
tx_valid  out  1  tx_data is valid
tx_last  out  1  marks the final FCS byte
tx_ready  in  1  sink accepts a byte
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
frames_sent  out  16  frames completed in the current run; cleared on start

Behaviour:
- Reset: RST_N low forces all outputs and state to 0 immediately (asynchronous) and returns the FSM to IDLE. This includes a reset mid-frame: the partial frame is abandoned and not resumed.
- Handshake: a beat transfers when tx_valid && tx_ready. Once tx_valid is high, tx_data and tx_last hold stable until the transfer. tx_valid never drops mid-frame.
- FSM states and transitions:
  - IDLE to HDR on start. busy rises and tx_valid is asserted the cycle after start is sampled.
  - HDR: 14 bytes (DST, SRC, ETHERTYPE), then PAYLOAD.
  - PAYLOAD: byte k of frame n = (n[7:0] + k[7:0]) mod 256, then FCS.
  - FCS: 4 bytes, then IFG. tx_last is high on the 4th FCS byte.
  - IFG: IFG_CYCLES cycles with tx_valid low, then HDR, or DONE when the run ends.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Run end: the run ends after num_frames frames, or after the frame in flight when stop is sampled (stop in IDLE is ignored). If stop and start coincide while IDLE, start wins and stop is ignored. num_frames = 0 with no stop runs forever. frames_sent increments on each tx_last transfer and wraps at 16 bits.
- Length rules:
  - Fixed mode: L = clamp(payload_len, PAYLOAD_MIN, PAYLOAD_MAX).
  - Incrementing mode: L(n) = PAYLOAD_MIN + (n mod (PAYLOAD_MAX-PAYLOAD_MIN+1)), so it wraps back to MIN after MAX.
  - Frame beats = 18 + L.
- FCS: IEEE CRC-32, reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, computed over header and payload. Sent LSB byte first. The CRC advances only on transferred beats and reinitialises at each frame start.
- Counters: byte index is 11-bit; frame index n is 16-bit and resets per run.

Decomposition:
- eth_pkg:
  - FSM state enum
  - HDR_LEN=14, FCS_LEN=4
  - CRC_POLY_REFL=32'hEDB88320, CRC_INIT=32'hFFFFFFFF
  - function clamp_len
- Sub-module eth_crc32_d8: registered byte-wise CRC with CLK, RST_N, init, en, data[7:0], crc[31:0] (crc is the final-XOR'd value).

Test Plan:
- Reset: RST_N=0 at any time -> tx_valid=0, tx_last=0, busy=0, done=0, frames_sent=0, with no clock edge required.
- Basic frame: start, num_frames=1, payload_len=46, LEN_MODE=0, tx_ready=1 -> 64 beats with this content, after which frames_sent=1, then 12 idle cycles, then a done pulse:
  - bytes 0-5 FF
  - bytes 6-11 02 00 00 00 00 01
  - bytes 12-13 88 B5
  - payload 00..2D
  - FCS equal to the bench CRC-32 model
  - tx_last only on beat 64
- Clamping: payload_len=10 -> 64-beat frame; payload_len=2000 -> 1518-beat frame.
- Backpressure: random tx_ready (50%) during a 3-frame run -> tx_data/tx_last held while stalled and byte stream identical to the tx_ready=1 run. Gaps are exactly 12 cycles low after each tx_last transfer, and frame 1 payload starts 01.
- Control corner cases:
  - stop mid-frame 2 of num_frames=0 -> frame 2 completes, then done; frames_sent=2.
  - start while busy -> no effect.
  - RST_N pulse at beat 20 -> outputs zero; a following start restarts at DST byte FF with n=0.
- CRC unit check: eth_crc32_d8 fed ASCII "123456789" -> crc=32'hCBF43926.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types, constants and helpers for the Ethernet frame generator.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG,
    ST_DONE
  } state_t;

  localparam int unsigned HDR_LEN       = 14;
  localparam int unsigned FCS_LEN       = 4;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

  // One byte of reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Registered byte-wise IEEE CRC-32; crc output already carries the final XOR.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    crc_q <= CRC_INIT;
    else if (init) crc_q <= CRC_INIT;
    else if (en)   crc_q <= crc_next(crc_q, data);
  end

  assign crc = ~crc_q;

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet L2 frame traffic generator: header, counting payload, CRC-32 FCS,
// valid/ready byte stream with configurable frame count, length mode and gap.
module eth_frame_gen
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned PAYLOAD_MIN = 46,
  parameter int unsigned PAYLOAD_MAX = 1500,
  parameter int unsigned IFG_CYCLES  = 12,   // must be >= 1
  parameter int unsigned LEN_MODE    = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_frames,
  input  logic [10:0] payload_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_sent
);

  localparam logic [10:0]  MIN_L       = 11'(PAYLOAD_MIN);
  localparam logic [10:0]  MAX_L       = 11'(PAYLOAD_MAX);
  localparam logic [10:0]  HDR_LAST    = 11'(HDR_LEN - 1);
  localparam logic [10:0]  FCS_PENULT  = 11'(FCS_LEN - 2);
  localparam logic [15:0]  GAP_LAST    = 16'(IFG_CYCLES - 1);
  localparam logic [127:0] HDR_WORDS   = {DST_MAC, SRC_MAC, ETHERTYPE, 16'h0000};

  state_t      state;
  logic [10:0] idx, len, len_first, len_next;
  logic [15:0] gap, num_q;
  logic        stop_pend, beat, run_end, crc_init, crc_en;
  logic [31:0] crc;
  logic [7:0]  hdr_byte [16];

  for (genvar g = 0; g < 16; g++) begin : g_hdr
    assign hdr_byte[g] = HDR_WORDS[8*(15-g) +: 8];
  end

  assign beat      = tx_valid & tx_ready;
  assign run_end   = stop_pend | stop | ((num_q != '0) && (frames_sent == num_q));
  assign len_first = (LEN_MODE != 0) ? MIN_L : clamp_len(payload_len, MIN_L, MAX_L);
  assign len_next  = (LEN_MODE != 0) ? ((len == MAX_L) ? MIN_L : len + 11'd1) : len;
  assign crc_init  = (state == ST_IDLE) || (state == ST_IFG) || (state == ST_DONE);
  assign crc_en    = beat && ((state == ST_HDR) || (state == ST_PAYLOAD));

  eth_crc32_d8 u_crc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .init  (crc_init),
    .en    (crc_en),
    .data  (tx_data),
    .crc   (crc)
  );

  // Data is decoded from registered state so the first FCS byte can use the
  // CRC register right after it absorbs the last payload byte.
  always_comb begin
    tx_data = '0;
    case (state)
      ST_HDR:     tx_data = hdr_byte[idx[3:0]];
      ST_PAYLOAD: tx_data = frames_sent[7:0] + idx[7:0];
      ST_FCS: begin
        case (idx[1:0])
          2'd0:    tx_data = crc[7:0];
          2'd1:    tx_data = crc[15:8];
          2'd2:    tx_data = crc[23:16];
          default: tx_data = crc[31:24];
        endcase
      end
      default: tx_data = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      idx         <= '0;
      len         <= '0;
      gap         <= '0;
      num_q       <= '0;
      stop_pend   <= 1'b0;
      frames_sent <= '0;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && busy) stop_pend <= 1'b1;
      case (state)
        ST_IDLE: if (start) begin
          state       <= ST_HDR;
          idx         <= '0;
          tx_valid    <= 1'b1;
          busy        <= 1'b1;
          frames_sent <= '0;
          num_q       <= num_frames;
          len         <= len_first;
          stop_pend   <= 1'b0;
        end
        ST_HDR: if (beat) begin
          if (idx == HDR_LAST) begin
            state <= ST_PAYLOAD;
            idx   <= '0;
          end else idx <= idx + 11'd1;
        end
        ST_PAYLOAD: if (beat) begin
          if (idx == len - 11'd1) begin
            state <= ST_FCS;
            idx   <= '0;
          end else idx <= idx + 11'd1;
        end
        ST_FCS: if (beat) begin
          if (tx_last) begin
            state       <= ST_IFG;
            gap         <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
            len         <= len_next;
          end else begin
            idx     <= idx + 11'd1;
            tx_last <= (idx == FCS_PENULT);
          end
        end
        ST_IFG: begin
          if (gap == GAP_LAST) begin
            if (run_end) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= ST_HDR;
              idx      <= '0;
              tx_valid <= 1'b1;
            end
          end else gap <= gap + 16'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Self-checking bench for eth_frame_gen against a queue-based frame model.
`timescale 1ns/1ps
module tb_eth_frame_gen;

  localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC   = 48'h0200_0000_0001;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam int          IFG   = 12;
  localparam int          CAPN  = 8192;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        start = 1'b0, stop = 1'b0, tx_ready = 1'b1;
  logic [15:0] num_frames = '0;
  logic [10:0] payload_len = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy, done;
  logic [15:0] frames_sent;

  logic        start2 = 1'b0;
  logic [7:0]  tx_data2;
  logic        tx_valid2, tx_last2, busy2, done2;
  logic [15:0] frames_sent2;

  logic        crc_init = 1'b0, crc_en = 1'b0;
  logic [7:0]  crc_data = '0;
  logic [31:0] crc_out;

  int          n_tests = 0, n_fail = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  frm[$];
  logic [8:0]  q2[$];
  logic [7:0]  cap [CAPN];
  int          cap_n = 0;
  logic [31:0] crc_tab [256];
  bit          rand_ready = 1'b0;

  eth_frame_gen u_dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop),
    .num_frames(num_frames), .payload_len(payload_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  eth_frame_gen #(.PAYLOAD_MIN(46), .PAYLOAD_MAX(48), .IFG_CYCLES(3), .LEN_MODE(1)) u_inc (
    .CLK(CLK), .RST_N(RST_N), .start(start2), .stop(1'b0),
    .num_frames(16'd4), .payload_len(11'd0),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_last(tx_last2), .tx_ready(1'b1),
    .busy(busy2), .done(done2), .frames_sent(frames_sent2)
  );

  eth_crc32_d8 u_crc (
    .CLK(CLK), .RST_N(RST_N), .init(crc_init), .en(crc_en), .data(crc_data), .crc(crc_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clampm(input int pl);
    return (pl < 46) ? 46 : ((pl > 1500) ? 1500 : pl);
  endfunction

  function automatic logic [31:0] crc_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic void build_frame(input int n, input int len);
    logic [7:0]  b[$];
    logic [31:0] c;
    for (int i = 0; i < 6; i++) b.push_back(8'(DST >> (40 - 8*i)));
    for (int i = 0; i < 6; i++) b.push_back(8'(SRC >> (40 - 8*i)));
    b.push_back(ETYPE[15:8]);
    b.push_back(ETYPE[7:0]);
    for (int k = 0; k < len; k++) b.push_back(8'((n + k) % 256));
    c = crc_of(b);
    frm.delete();
    foreach (b[i]) frm.push_back({1'b0, b[i]});
    for (int j = 0; j < 4; j++) frm.push_back({(j == 3), 8'(c >> (8*j))});
  endfunction

  // ---------------- compare process ----------------
  bit         held_v = 1'b0, gap_pend = 1'b0;
  logic [7:0] held_d;
  logic       held_l;
  int         gap_cnt = 0;
  logic [8:0] e;

  always @(negedge CLK) begin
    if (!RST_N) begin
      held_v   = 1'b0;
      gap_pend = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 32'(tx_valid), 1);
        chk("stall_data", 32'(tx_data), 32'(held_d));
        chk("stall_last", 32'(tx_last), 32'(held_l));
      end
      if (gap_pend) begin
        if (tx_valid || done) begin
          chk("ifg_cycles", gap_cnt, IFG);
          gap_pend = 1'b0;
        end else gap_cnt++;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(tx_data), 32'(e[7:0]));
          chk("beat_last", 32'(tx_last), 32'(e[8]));
        end
        if (cap_n < CAPN) cap[cap_n] = tx_data;
        cap_n++;
        if (tx_last) begin
          gap_pend = 1'b1;
          gap_cnt  = 0;
        end
      end
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
      held_l = tx_last;
    end
  end

  always @(negedge CLK) if (RST_N && tx_valid2) q2.push_back({tx_last2, tx_data2});

  initial forever begin
    @(posedge CLK);
    #2 tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input bit with_stop);
    @(posedge CLK);
    #1 start = 1'b1;
    stop = with_stop;
    @(posedge CLK);
    #1 start = 1'b0;
    stop = 1'b0;
    chk("valid_after_start", 32'(tx_valid), 1);
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic recover();
    @(negedge CLK);
    #1 RST_N = 1'b0;
    exp_q.delete();
    #4 RST_N = 1'b1;
  endtask

  task automatic wait_done(input int exp_fs, input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge CLK);
      c++;
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 0, 1);
      recover();
      return;
    end
    chk("done_busy_low", 32'(busy), 0);
    chk("done_frames_sent", 32'(frames_sent), 32'(exp_fs));
    @(negedge CLK);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (cap_n < n && c < 20000) begin
      @(negedge CLK);
      c++;
    end
    if (cap_n < n) chk("beat_wait_timeout", cap_n, n);
  endtask

  task automatic load_frames(input int nf, input int len);
    for (int n = 0; n < nf; n++) begin
      build_frame(n, len);
      foreach (frm[i]) exp_q.push_back(frm[i]);
    end
  endtask

  task automatic run(input int nf, input int pl, input bit rr, input bit with_stop);
    int len;
    len = clampm(pl);
    cap_n = 0;
    load_frames(nf, len);
    rand_ready  = rr;
    num_frames  = 16'(nf);
    payload_len = 11'(pl);
    pulse_start(with_stop);
    wait_done(nf, nf * ((len + 18) * 8 + IFG + 10) + 50);
    chk("stream_drained", exp_q.size(), 0);
    chk("beat_count", cap_n, nf * (len + 18));
    rand_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int         li [8] = '{0, 5, 6, 11, 12, 13, 14, 59};
  logic [7:0] lv [8] = '{8'hFF, 8'hFF, 8'h02, 8'h01, 8'h88, 8'hB5, 8'h00, 8'h2D};
  int         exp_len2 [4] = '{64, 65, 66, 64};

  initial begin
    logic [7:0]  s[$];
    logic [31:0] r;
    int          len, mism, fl, fi, c;

    for (int i = 0; i < 256; i++) begin
      r = 32'(i);
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tab[i] = r;
    end
    for (int i = 0; i < 9; i++) s.push_back(8'(8'h31 + i));
    chk("model_crc_123456789", crc_of(s), 32'hCBF43926);

    // Asynchronous reset before the first clock edge
    #1 RST_N = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_frames_sent", 32'(frames_sent), 0);
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;

    // CRC unit on "123456789"
    @(posedge CLK); #1 crc_init = 1'b1;
    @(posedge CLK); #1 crc_init = 1'b0; crc_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      crc_data = 8'(8'h31 + i);
      @(posedge CLK); #1;
    end
    crc_en = 1'b0;
    chk("crc_unit_123456789", crc_out, 32'hCBF43926);

    // Basic frame with hand-computed bytes
    run(1, 46, 1'b0, 1'b0);
    foreach (li[i]) chk("basic_literal_byte", 32'(cap[li[i]]), 32'(lv[i]));
    chk("basic_beats_64", cap_n, 64);

    // Clamping
    run(1, 10, 1'b0, 1'b0);
    chk("clamp_low_beats", cap_n, 64);
    run(1, 2000, 1'b0, 1'b0);
    chk("clamp_high_beats", cap_n, 1518);

    // Backpressure over three frames
    run(3, 46, 1'b1, 1'b0);
    chk("bp_frame1_payload0", 32'(cap[64 + 14]), 32'h01);
    chk("bp_frame2_payload0", 32'(cap[128 + 14]), 32'h02);

    // start and stop together in IDLE: start wins, stop ignored
    run(2, 50, 1'b0, 1'b1);

    // Continuous run: start while busy ignored, stop during frame index 1
    len = clampm(60);
    cap_n = 0;
    load_frames(2, len);
    rand_ready = 1'b1;
    num_frames = 16'd0;
    payload_len = 11'd60;
    pulse_start(1'b0);
    wait_beats(5);
    @(posedge CLK); #1 start = 1'b1; payload_len = 11'd200;
    @(posedge CLK); #1 start = 1'b0;
    wait_beats(len + 18 + 10);
    @(posedge CLK); #1 stop = 1'b1;
    @(posedge CLK); #1 stop = 1'b0;
    wait_done(2, 4000);
    chk("stop_drained", exp_q.size(), 0);
    chk("stop_beats", cap_n, 2 * (len + 18));
    rand_ready = 1'b0;

    // Reset in the middle of a frame, then restart
    cap_n = 0;
    load_frames(1, 46);
    num_frames = 16'd1;
    payload_len = 11'd46;
    pulse_start(1'b0);
    wait_beats(20);
    #1 RST_N = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_tx_last", 32'(tx_last), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_frames_sent", 32'(frames_sent), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b1;
    run(1, 46, 1'b0, 1'b0);
    chk("restart_first_byte", 32'(cap[0]), 32'hFF);
    chk("restart_payload0", 32'(cap[14]), 32'h00);

    // Randomized runs
    for (int k = 0; k < 5; k++)
      run($urandom_range(1, 3), $urandom_range(0, 140), 1'($urandom_range(0, 1)), 1'b0);

    // Incrementing length mode, lengths 46..48 wrapping
    q2.delete();
    @(posedge CLK); #1 start2 = 1'b1;
    @(posedge CLK); #1 start2 = 1'b0;
    c = 0;
    while (done2 !== 1'b1 && c < 2000) begin
      @(negedge CLK);
      c++;
    end
    chk("inc_done_seen", 32'(done2), 1);
    chk("inc_frames_sent", 32'(frames_sent2), 4);
    chk("inc_busy_low", 32'(busy2), 0);
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      build_frame(n, 46 + (n % 3));
      foreach (frm[i]) exp_q.push_back(frm[i]);
    end
    chk("inc_total_beats", q2.size(), exp_q.size());
    mism = 0;
    foreach (q2[i]) if (i < exp_q.size() && q2[i] !== exp_q[i]) mism++;
    chk("inc_stream_mismatches", mism, 0);
    exp_q.delete();
    fl = 0;
    fi = 0;
    foreach (q2[i]) begin
      fl++;
      if (q2[i][8]) begin
        if (fi < 4) chk("inc_frame_len", fl, exp_len2[fi]);
        fi++;
        fl = 0;
      end
    end
    chk("inc_frame_count", fi, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
